// File: rtl/stim_gen.sv
// ---------------------------------------------------------------------------
// stim_gen
// Stimulus pattern generator. On an accepted start it walks an index through
// a sequence, maps each index to a vector (binary-up, Gray, walking-one or
// binary-down), holds every vector for STEP clocks and then reports
// completion with a single-cycle done pulse.
//
// Parameters
//   WIDTH    vector / index width (2..16)
//   STEP     clocks each vector is held (1..255)
//
// Ports
//   i_clk    clock, all state updates on the rising edge
//   i_rst    synchronous active-high reset
//   i_start  start request, only looked at while idle
//   i_abort  abort request, returns to idle from any state
//   i_mode   pattern select, latched when a start is accepted
//   o_vec    current stimulus vector
//   o_valid  one-cycle pulse in the first cycle of each new vector
//   o_busy   high for every cycle a sequence vector is being driven
//   o_done   one-cycle pulse when a sequence completes normally
//   o_idx    index of the current vector within the sequence
// ---------------------------------------------------------------------------
module stim_gen #(
    parameter int WIDTH = 5,
    parameter int STEP  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_vec,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]       STEP_LAST     = 8'(STEP - 1);
    localparam logic [WIDTH-1:0] IDX_LAST_FULL = '1;
    localparam logic [WIDTH-1:0] IDX_LAST_WALK = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE           = WIDTH'(1);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_idx;
    logic [WIDTH-1:0] w_idxNext;
    logic [7:0]       r_step;
    logic [7:0]       w_stepNext;
    logic [1:0]       r_mode;
    logic [1:0]       w_modeNext;
    logic             w_load;
    logic             w_wrap;
    logic             w_isLast;
    logic             w_busyNext;
    logic [WIDTH-1:0] w_vecMap;

    // Sequence-end and step-wrap detection. The walking-one pattern is only
    // WIDTH vectors long; the counting patterns stop at the all-ones index
    // instead of letting the index roll over.
    always_comb begin
        w_wrap   = (r_step == STEP_LAST);
        w_isLast = (r_mode == 2'd2) ? (r_idx == IDX_LAST_WALK)
                                    : (r_idx == IDX_LAST_FULL);
    end

    // Index-to-vector mapping for the latched pattern.
    always_comb begin
        w_vecMap = r_idx;
        case (r_mode)
            2'd0:    w_vecMap = r_idx;
            2'd1:    w_vecMap = r_idx ^ (r_idx >> 1);
            2'd2:    w_vecMap = ONE << r_idx;
            default: w_vecMap = ~r_idx;
        endcase
    end

    // Next-state logic. The internal index/step counters run one cycle
    // ahead of the registered outputs, so vector 0 appears on the edge
    // after the start edge and the done pulse lands one edge after the
    // last vector finishes.
    always_comb begin
        w_nextState = r_state;
        w_idxNext   = r_idx;
        w_stepNext  = r_step;
        w_modeNext  = r_mode;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    w_nextState = RUN;
                    w_idxNext   = '0;
                    w_stepNext  = '0;
                    w_modeNext  = i_mode;
                end
            end
            RUN: begin
                if (i_abort) begin
                    w_nextState = IDLE;
                end else begin
                    w_load = 1'b1;
                    if (w_wrap) begin
                        w_stepNext = '0;
                        if (w_isLast) begin
                            w_nextState = DONE;
                        end else begin
                            w_idxNext = r_idx + ONE;
                        end
                    end else begin
                        w_stepNext = r_step + 8'd1;
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        w_busyNext = (r_state == RUN) && !i_abort;
    end

    // State and sequence counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_step  <= '0;
            r_mode  <= 2'd0;
        end else begin
            r_state <= w_nextState;
            r_idx   <= w_idxNext;
            r_step  <= w_stepNext;
            r_mode  <= w_modeNext;
        end
    end

    // Registered outputs. Vector and index only move while a sequence is
    // actively running, so they hold their last value through abort, DONE
    // and IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vec   <= '0;
            o_idx   <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_valid <= w_load && (r_step == 8'd0);
            o_busy  <= w_busyNext;
            o_done  <= (r_state == DONE);
            if (w_load) begin
                o_vec <= w_vecMap;
                o_idx <= r_idx;
            end
        end
    end

endmodule
